// File: rtl/bsg_cgol_pkg.sv
// bsg_cgol_pkg: shared types and sizing helpers for the CGOL board blocks
package bsg_cgol_pkg;

    typedef enum logic {eIdle, eSend} bsg_cgol_reader_state_e;

    function automatic int bsg_cgol_row_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_cgol_board_reader.sv
// bsg_cgol_board_reader: snapshots the cell grid on request and streams it out
// one row per beat over valid/yumi, counting fully delivered frames.
module bsg_cgol_board_reader
    import bsg_cgol_pkg::*;
#(
    parameter int board_width_p     = 4,
    parameter int frame_cnt_width_p = 8
) (
    input  logic                                         clk_i,
    input  logic                                         reset_n_i,
    input  logic [board_width_p*board_width_p-1:0]       board_i,
    input  logic                                         v_i,
    output logic                                         ready_o,
    output logic                                         v_o,
    output logic [board_width_p-1:0]                     data_o,
    output logic [bsg_cgol_row_width(board_width_p)-1:0] row_o,
    output logic                                         last_o,
    input  logic                                         yumi_i,
    output logic [frame_cnt_width_p-1:0]                 frame_cnt_o
);

    localparam int row_w_lp = bsg_cgol_row_width(board_width_p);
    localparam logic [row_w_lp-1:0] last_row_lp = row_w_lp'(board_width_p - 1);

    bsg_cgol_reader_state_e state_q, state_d;
    logic [board_width_p-1:0][board_width_p-1:0] snap_q, snap_d;
    logic [row_w_lp-1:0] row_q, row_d;
    logic [frame_cnt_width_p-1:0] frame_q, frame_d;
    logic capture, accept, done;

    assign capture = (state_q == eIdle) && v_i;
    assign accept  = (state_q == eSend) && yumi_i;
    assign done    = accept && (row_q == last_row_lp);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eIdle;
            snap_q  <= '0;
            row_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            row_q   <= row_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = capture ? eSend : (done ? eIdle : state_q);
        snap_d  = capture ? board_i : snap_q;
        row_d   = (capture || done) ? '0 : (accept ? row_q + 1'b1 : row_q);
        frame_d = done ? frame_q + 1'b1 : frame_q;
    end

    // Outputs depend only on registered state; no input reaches them combinationally.
    always_comb begin
        ready_o     = (state_q == eIdle);
        v_o         = (state_q == eSend);
        last_o      = v_o && (row_q == last_row_lp);
        data_o      = snap_q[row_q];
        row_o       = row_q;
        frame_cnt_o = frame_q;
    end

endmodule

// File: tb/tb_bsg_cgol_board_reader.sv
// tb_bsg_cgol_board_reader: directed and random checks against a queue-based reference model
module tb_bsg_cgol_board_reader;

    localparam int W = 4;
    localparam int F = 2;

    logic           clk = 1'b0;
    logic           reset_n_i;
    logic [W*W-1:0] board_i;
    logic           v_i;
    logic           yumi_i;
    logic           ready_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic [1:0]     row_o;
    logic           last_o;
    logic [F-1:0]   frame_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: pending beats as a queue of rows, plus a plain frame tally.
    int beats[$];
    int frames = 0;

    bsg_cgol_board_reader #(.board_width_p(W), .frame_cnt_width_p(F)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .board_i(board_i), .v_i(v_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .row_o(row_o),
        .last_o(last_o), .yumi_i(yumi_i), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit busy = beats.size() > 0;
        int row = W - beats.size();
        chk({tag, ".v"}, v_o, busy);
        chk({tag, ".ready"}, ready_o, !busy);
        chk({tag, ".frames"}, frame_cnt_o, frames % (1 << F));
        if (busy) begin
            chk({tag, ".data"}, data_o, beats[0]);
            chk({tag, ".row"}, row_o, row);
            chk({tag, ".last"}, last_o, row == W - 1);
        end else
            chk({tag, ".last"}, last_o, 0);
    endtask

    task automatic tick(input string tag);
        if (beats.size() == 0) begin
            if (v_i) for (int r = 0; r < W; r++) beats.push_back(int'((board_i >> (r * W)) & ((1 << W) - 1)));
        end else if (yumi_i) begin
            void'(beats.pop_front());
            if (beats.size() == 0) frames++;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic run_frame(input logic [W*W-1:0] b, input string tag);
        board_i = b; v_i = 1'b1; yumi_i = 1'b0;
        tick({tag, ".cap"});
        v_i = 1'b0; yumi_i = 1'b1;
        for (int i = 0; i < W; i++) tick({tag, ".beat"});
        yumi_i = 1'b0;
    endtask

    initial begin
        reset_n_i = 1'b0; board_i = '0; v_i = 1'b1; yumi_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("reset");
        end
        reset_n_i = 1'b1;
        board_i = 16'hA5C3;
        tick("first_cap");
        chk("first_cap.row0", row_o, 0);
        v_i = 1'b0; yumi_i = 1'b1;
        chk("a5c3.r0", data_o, 4'h3);
        tick("a5c3"); chk("a5c3.r1", data_o, 4'hC);
        tick("a5c3"); chk("a5c3.r2", data_o, 4'h5);
        tick("a5c3"); chk("a5c3.r3", data_o, 4'hA); chk("a5c3.last3", last_o, 1);
        tick("a5c3.end");
        chk("a5c3.cnt", frame_cnt_o, 1);
        yumi_i = 1'b0;

        board_i = 16'h1234; v_i = 1'b1;
        tick("bp.cap");
        v_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick("bp.hold");
            chk("bp.hold_data", data_o, 4'h4);
        end
        yumi_i = 1'b1;
        for (int i = 0; i < W; i++) tick("bp.drain");
        yumi_i = 1'b0;

        board_i = 16'hFFFF; v_i = 1'b1;
        tick("iso.cap");
        board_i = '0; yumi_i = 1'b1;
        for (int i = 0; i < W; i++) begin
            chk("iso.data", data_o, 4'hF);
            tick("iso.beat");
        end
        chk("iso.cnt", frame_cnt_o, 3);
        v_i = 1'b0; yumi_i = 1'b0;

        board_i = 16'h9E61; v_i = 1'b1;
        tick("rst.cap");
        v_i = 1'b0; yumi_i = 1'b1;
        tick("rst.r0");
        tick("rst.r1");
        yumi_i = 1'b0;
        reset_n_i = 1'b0;
        #1;
        chk("rst.async_v", v_o, 0);
        chk("rst.async_ready", ready_o, 1);
        chk("rst.async_cnt", frame_cnt_o, 0);
        beats.delete(); frames = 0;
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;
        run_frame(16'h0F0F, "rst.restart");

        reset_n_i = 1'b0;
        #1;
        beats.delete(); frames = 0;
        #1;
        reset_n_i = 1'b1;
        for (int f = 0; f < 5; f++) begin
            run_frame(16'(f * 16'h1111 + 16'h0123), "wrap");
            chk("wrap.seq", frame_cnt_o, (f + 1) % 4);
        end

        for (int i = 0; i < 400; i++) begin
            board_i = 16'($urandom);
            v_i = 1'($urandom % 3 == 0);
            yumi_i = 1'($urandom % 2);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
